// File: rtl/fsm_run_detect_if.sv
// Symbol-stream bundle for fsm_run_detect: strobed symbol inputs plus the registered status outputs.
// i_valid is a plain strobe with no back-pressure: i_data/i_mode are consumed on every rising
// edge where i_valid=1 and i_clear=0; i_clear=1 wins over i_valid on the same edge.
interface fsm_run_detect_if #(
  parameter int DATA_W = 2,
  parameter int CNT_W  = 4
);
  logic              i_valid;
  logic [DATA_W-1:0] i_data;
  logic              i_clear;
  logic              i_mode;
  logic              o_detect;
  logic              o_pulse;
  logic              o_class;
  logic [CNT_W-1:0]  o_run_cnt;
  logic [1:0]        o_state;

  modport master (
    output i_valid, i_data, i_clear, i_mode,
    input  o_detect, o_pulse, o_class, o_run_cnt, o_state
  );

  modport slave (
    input  i_valid, i_data, i_clear, i_mode,
    output o_detect, o_pulse, o_class, o_run_cnt, o_state
  );
endinterface

// File: rtl/fsm_run_detect.sv
// Moore run-length detector: classifies accepted symbols by MSB and flags runs of RUN_LEN
// same-class symbols, with overlapping/non-overlapping modes, a saturating run counter and an event pulse.
module fsm_run_detect #(
  parameter int DATA_W  = 2,
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 4
) (
  input  logic            clk,
  input  logic            rstn,
  fsm_run_detect_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DET  = 2'd2,
    S_BAD  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] RUN_LEN_C   = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam state_e           START_STATE = (RUN_LEN == 1) ? S_DET : S_RUN;
  localparam logic             START_PULSE = (RUN_LEN == 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cls_q, cls_d;
  logic             pulse_q, pulse_d;
  logic             sym_cls;
  logic [CNT_W-1:0] cnt_inc;

  assign sym_cls = bus.i_data[DATA_W-1];
  assign cnt_inc = cnt_q + CNT_ONE;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cls_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cls_q   <= cls_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cls_d   = cls_q;
    pulse_d = 1'b0;
    if (state_q == S_BAD || bus.i_clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      cls_d   = 1'b0;
    end else if (bus.i_valid) begin
      // Default action for an accepted symbol: it opens a fresh run of length 1.
      state_d = START_STATE;
      cnt_d   = CNT_ONE;
      cls_d   = sym_cls;
      pulse_d = START_PULSE;
      case (state_q)
        S_RUN: begin
          if (sym_cls == cls_q) begin
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == RUN_LEN_C) ? S_DET : S_RUN;
            pulse_d = (cnt_inc == RUN_LEN_C);
          end
        end
        S_DET: begin
          // Overlapping mode extends the detected run without a new event.
          if (sym_cls == cls_q && !bus.i_mode) begin
            state_d = S_DET;
            cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_inc;
            pulse_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_detect  = (state_q == S_DET);
  assign bus.o_pulse   = pulse_q;
  assign bus.o_class   = cls_q;
  assign bus.o_run_cnt = cnt_q;
  assign bus.o_state   = (state_q == S_BAD) ? S_IDLE : state_q;

endmodule

// File: tb/tb_fsm_run_detect.sv
// Bench for fsm_run_detect: four parameter variants share one class stream; vector table,
// hand sequences and a randomized phase checked against an integer run-length model.
module tb_fsm_run_detect;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       valid = 1'b0;
  logic       clr = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] d = 4'd0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // a: defaults, b: RUN_LEN=3, c: CNT_W=2, d: RUN_LEN=1 DATA_W=4
  fsm_run_detect_if #(.DATA_W(2), .CNT_W(4)) if_a ();
  fsm_run_detect_if #(.DATA_W(2), .CNT_W(4)) if_b ();
  fsm_run_detect_if #(.DATA_W(2), .CNT_W(2)) if_c ();
  fsm_run_detect_if #(.DATA_W(4), .CNT_W(4)) if_d ();

  fsm_run_detect #(.DATA_W(2), .RUN_LEN(2), .CNT_W(4)) dut_a (.clk(clk), .rstn(rstn), .bus(if_a));
  fsm_run_detect #(.DATA_W(2), .RUN_LEN(3), .CNT_W(4)) dut_b (.clk(clk), .rstn(rstn), .bus(if_b));
  fsm_run_detect #(.DATA_W(2), .RUN_LEN(2), .CNT_W(2)) dut_c (.clk(clk), .rstn(rstn), .bus(if_c));
  fsm_run_detect #(.DATA_W(4), .RUN_LEN(1), .CNT_W(4)) dut_d (.clk(clk), .rstn(rstn), .bus(if_d));

  assign if_a.i_valid = valid; assign if_a.i_clear = clr; assign if_a.i_mode = mode;
  assign if_b.i_valid = valid; assign if_b.i_clear = clr; assign if_b.i_mode = mode;
  assign if_c.i_valid = valid; assign if_c.i_clear = clr; assign if_c.i_mode = mode;
  assign if_d.i_valid = valid; assign if_d.i_clear = clr; assign if_d.i_mode = mode;
  assign if_a.i_data = {d[3], d[0]};
  assign if_b.i_data = {d[3], d[0]};
  assign if_c.i_data = {d[3], d[0]};
  assign if_d.i_data = d;

  // Observation word: {state[1:0], detect, pulse, cnt[3:0], class}
  logic [8:0] obs [4];
  assign obs[0] = {if_a.o_state, if_a.o_detect, if_a.o_pulse, if_a.o_run_cnt, if_a.o_class};
  assign obs[1] = {if_b.o_state, if_b.o_detect, if_b.o_pulse, if_b.o_run_cnt, if_b.o_class};
  assign obs[2] = {if_c.o_state, if_c.o_detect, if_c.o_pulse, 2'b00, if_c.o_run_cnt, if_c.o_class};
  assign obs[3] = {if_d.o_state, if_d.o_detect, if_d.o_pulse, if_d.o_run_cnt, if_d.o_class};

  // Reference model: unbounded integer run length per variant
  int   rl   [4] = '{2, 3, 2, 1};
  int   cmax [4] = '{15, 15, 3, 15};
  int   m_run   [4];
  logic m_cls   [4];
  logic m_pulse [4];

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_run[k] = 0; m_cls[k] = 1'b0; m_pulse[k] = 1'b0;
    end
  endtask

  task automatic model_step(input logic v, input logic c_in, input logic md, input logic c);
    for (int k = 0; k < 4; k++) begin
      m_pulse[k] = 1'b0;
      if (c_in) begin
        m_run[k] = 0; m_cls[k] = 1'b0;
      end else if (v) begin
        if (m_run[k] == 0 || c != m_cls[k] || (md && m_run[k] >= rl[k])) m_run[k] = 1;
        else m_run[k] = m_run[k] + 1;
        m_cls[k] = c;
        m_pulse[k] = (m_run[k] == rl[k]);
      end
    end
  endtask

  function automatic logic [8:0] model_exp(input int k);
    logic [1:0] st;
    int         cnt;
    st  = (m_run[k] == 0) ? 2'd0 : ((m_run[k] >= rl[k]) ? 2'd2 : 2'd1);
    cnt = (m_run[k] > cmax[k]) ? cmax[k] : m_run[k];
    return {st, (m_run[k] >= rl[k]), m_pulse[k], 4'(cnt), m_cls[k]};
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act{st,det,pul,cnt,cls}=%b_%b_%b_%b_%b exp=%b_%b_%b_%b_%b", name,
               act[8:7], act[6], act[5], act[4:1], act[0], exp[8:7], exp[6], exp[5], exp[4:1], exp[0]);
    end
  endtask

  // Inputs are set at posedge+1; this advances one edge and returns at the next posedge+1.
  task automatic step();
    logic v, c_in, md, c;
    v = valid; c_in = clr; md = mode; c = d[3];
    @(posedge clk);
    #1;
    model_step(v, c_in, md, c);
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    model_reset();
    #1;
    rstn = 1'b1;
  endtask

  task automatic drive(input logic v, input logic c_in, input logic md, input logic [3:0] dv);
    valid = v; clr = c_in; mode = md; d = dv;
  endtask

  function automatic logic [3:0] sym2(input logic [1:0] s);
    return {s[1], 2'b00, s[0]};
  endfunction

  typedef struct {
    logic       v;
    logic       c_in;
    logic       md;
    logic [1:0] sym;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [3:0] sc_cnt [6];
    logic       sc_det [6];
    logic       sc_pul [6];
    logic       cur_cls;

    //            v     clr   md    sym         st    det   pul   cnt    cls
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, {2'd1, 1'b0, 1'b0, 4'd1, 1'b0}};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 2'b01, {2'd2, 1'b1, 1'b1, 4'd2, 1'b0}};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 2'b01, {2'd2, 1'b1, 1'b0, 4'd3, 1'b0}};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 2'b11, {2'd1, 1'b0, 1'b0, 4'd1, 1'b1}};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 2'b00, {2'd0, 1'b0, 1'b0, 4'd0, 1'b0}};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 2'b00, {2'd1, 1'b0, 1'b0, 4'd1, 1'b0}};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 2'b11, {2'd1, 1'b0, 1'b0, 4'd1, 1'b0}};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 2'b11, {2'd1, 1'b0, 1'b0, 4'd1, 1'b0}};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 2'b11, {2'd1, 1'b0, 1'b0, 4'd1, 1'b0}};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 2'b11, {2'd1, 1'b0, 1'b0, 4'd1, 1'b0}};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 2'b01, {2'd2, 1'b1, 1'b1, 4'd2, 1'b0}};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 2'b10, {2'd0, 1'b0, 1'b0, 4'd0, 1'b0}};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 2'b10, {2'd1, 1'b0, 1'b0, 4'd1, 1'b1}};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 2'b11, {2'd2, 1'b1, 1'b1, 4'd2, 1'b1}};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 2'b11, {2'd1, 1'b0, 1'b0, 4'd1, 1'b1}};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 2'b10, {2'd2, 1'b1, 1'b1, 4'd2, 1'b1}};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 2'b10, {2'd2, 1'b1, 1'b0, 4'd3, 1'b1}};

    // Clock/reset
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) check($sformatf("reset_%0d", k), obs[k], 9'd0);
    rstn = 1'b1;

    // Vector table on the default variant
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].v, tbl[i].c_in, tbl[i].md, sym2(tbl[i].sym));
      step();
      check($sformatf("tbl_%0d", i), obs[0], tbl[i].exp);
    end

    // RUN_LEN=3, mode1, six symbols of class 1
    pulse_reset();
    sc_cnt = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3};
    sc_det = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    sc_pul = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b1, sym2(2'b10));
      step();
      check($sformatf("rl3_m1_%0d", i), obs[1],
            {(sc_det[i] ? 2'd2 : 2'd1), sc_det[i], sc_pul[i], sc_cnt[i], 1'b1});
    end

    // CNT_W=2 saturation in overlapping mode
    pulse_reset();
    sc_cnt = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd0};
    sc_det = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    sc_pul = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, sym2(2'b11));
      step();
      check($sformatf("sat_%0d", i), obs[2],
            {(sc_det[i] ? 2'd2 : 2'd1), sc_det[i], sc_pul[i], sc_cnt[i], 1'b1});
    end

    // RUN_LEN=1, DATA_W=4, mode1: every symbol is its own detection
    pulse_reset();
    drive(1'b1, 1'b0, 1'b1, 4'b1000); step();
    check("rl1_0", obs[3], {2'd2, 1'b1, 1'b1, 4'd1, 1'b1});
    drive(1'b1, 1'b0, 1'b1, 4'b1111); step();
    check("rl1_1", obs[3], {2'd2, 1'b1, 1'b1, 4'd1, 1'b1});
    drive(1'b1, 1'b0, 1'b1, 4'b0001); step();
    check("rl1_2", obs[3], {2'd2, 1'b1, 1'b1, 4'd1, 1'b0});

    // Async reset mid-run, then first symbol behaves as from IDLE
    pulse_reset();
    drive(1'b1, 1'b0, 1'b0, sym2(2'b01)); step();
    drive(1'b1, 1'b0, 1'b0, sym2(2'b00)); step();
    check("pre_rst", obs[0], {2'd2, 1'b1, 1'b1, 4'd2, 1'b0});
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    rstn = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 4; k++) check($sformatf("async_rst_%0d", k), obs[k], 9'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, sym2(2'b11)); step();
    check("post_rst", obs[0], {2'd1, 1'b0, 1'b0, 4'd1, 1'b1});

    // Randomized phase against the model, all variants
    pulse_reset();
    cur_cls = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) pulse_reset();
      if ($urandom_range(0, 4) == 0) cur_cls = ~cur_cls;
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      valid = ($urandom_range(0, 3) != 0);
      clr   = ($urandom_range(0, 24) == 0);
      d     = {cur_cls, 3'($urandom_range(0, 7))};
      step();
      for (int k = 0; k < 4; k++) check($sformatf("rand_%0d_dut%0d", i, k), obs[k], model_exp(k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
